// File: rtl/cache_ctrl_if.sv
// Bundle of pipeline request, cache-array and backing-memory signals for cache_ctrl.
// The master modport is the controller's view; slave is the surrounding environment.
interface cache_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req;
    logic             wr;
    logic [15:0]      addr;
    logic [15:0]      wdata;
    logic             busy;
    logic             done;
    logic [15:0]      rdata;
    logic             err;

    logic [7:0]       c_index;
    logic [1:0]       c_offset;
    logic             c_data_wr;
    logic [15:0]      c_data_in;
    logic [15:0]      c_data_out;
    logic             c_tag_wr;
    logic [TAG_W:0]   c_tag_in;
    logic [TAG_W:0]   c_tag_out;
    logic             c_dirty_wr;
    logic             c_dirty_in;
    logic             c_dirty_out;

    logic             mem_req;
    logic             mem_wr;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic             mem_stall;
    logic             mem_rvalid;
    logic [15:0]      mem_rdata;

    modport master (
        input  req, wr, addr, wdata,
        output busy, done, rdata, err,
        output c_index, c_offset, c_data_wr, c_data_in,
        input  c_data_out,
        output c_tag_wr, c_tag_in,
        input  c_tag_out,
        output c_dirty_wr, c_dirty_in,
        input  c_dirty_out,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_stall, mem_rvalid, mem_rdata
    );

    modport slave (
        output req, wr, addr, wdata,
        input  busy, done, rdata, err,
        input  c_index, c_offset, c_data_wr, c_data_in,
        output c_data_out,
        input  c_tag_wr, c_tag_in,
        output c_tag_out,
        input  c_dirty_wr, c_dirty_in,
        output c_dirty_out,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_stall, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: hit path, dirty-line write-back,
// word-by-word refill, then replay of the lookup.
module cache_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input logic          clk,
    input logic          rst,
    cache_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCmp,
        StWb,
        StFillReq,
        StFillWait,
        StFillTag
    } state_e;

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic             wr_q;
    logic             err_q;

    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] old_tag;
    logic [7:0]       idx;
    logic [1:0]       off;
    logic             line_valid;
    logic             hit;

    assign tag        = addr_q[15 -: TAG_W];
    assign idx        = addr_q[10:3];
    assign off        = addr_q[2:1];
    assign old_tag    = bus.c_tag_out[TAG_W-1:0];
    assign line_valid = bus.c_tag_out[TAG_W];
    assign hit        = line_valid && (old_tag == tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            addr_q  <= 16'h0;
            wdata_q <= 16'h0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        if (bus.addr[0]) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= bus.addr;
                            wdata_q <= bus.wdata;
                            wr_q    <= bus.wr;
                            state_q <= StCmp;
                        end
                    end
                end
                StCmp: begin
                    if (hit) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= 2'd0;
                        state_q <= (line_valid && bus.c_dirty_out) ? StWb : StFillReq;
                    end
                end
                StWb: begin
                    // Counter wraps to 0 after word 3, ready for the refill.
                    if (!bus.mem_stall) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_q <= StFillReq;
                    end
                end
                StFillReq: begin
                    if (!bus.mem_stall) state_q <= StFillWait;
                end
                StFillWait: begin
                    if (bus.mem_rvalid) begin
                        if (cnt_q != 2'd3) begin
                            cnt_q   <= cnt_q + 2'd1;
                            state_q <= StFillReq;
                        end else begin
                            state_q <= StFillTag;
                        end
                    end
                end
                StFillTag: state_q <= StCmp;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.done       = 1'b0;
        bus.rdata      = 16'h0;
        bus.err        = err_q;
        bus.c_index    = 8'h0;
        bus.c_offset   = 2'd0;
        bus.c_data_wr  = 1'b0;
        bus.c_data_in  = 16'h0;
        bus.c_tag_wr   = 1'b0;
        bus.c_tag_in   = '0;
        bus.c_dirty_wr = 1'b0;
        bus.c_dirty_in = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = 16'h0;
        bus.mem_wdata  = 16'h0;
        unique case (state_q)
            StIdle: ;
            StCmp: begin
                bus.c_index  = idx;
                bus.c_offset = off;
                if (hit) begin
                    bus.done = 1'b1;
                    if (wr_q) begin
                        bus.c_data_wr  = 1'b1;
                        bus.c_data_in  = wdata_q;
                        bus.c_dirty_wr = 1'b1;
                        bus.c_dirty_in = 1'b1;
                    end else begin
                        bus.rdata = bus.c_data_out;
                    end
                end
            end
            StWb: begin
                bus.c_index   = idx;
                bus.c_offset  = cnt_q;
                bus.mem_req   = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = {old_tag, idx, cnt_q, 1'b0};
                bus.mem_wdata = bus.c_data_out;
            end
            StFillReq: begin
                bus.c_index  = idx;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag, idx, cnt_q, 1'b0};
            end
            StFillWait: begin
                bus.c_index   = idx;
                bus.c_offset  = cnt_q;
                bus.c_data_in = bus.mem_rdata;
                bus.c_data_wr = bus.mem_rvalid;
            end
            StFillTag: begin
                bus.c_index    = idx;
                bus.c_tag_wr   = 1'b1;
                bus.c_tag_in   = {1'b1, tag};
                bus.c_dirty_wr = 1'b1;
                bus.c_dirty_in = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural storage arrays and a backing
// memory whose read data is address ^ 16'hA5A5.
module tb_cache_ctrl;

    logic clk;
    logic rst;

    cache_ctrl_if #(.TAG_W(5)) bus ();

    cache_ctrl #(.TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Storage arrays: combinational read, write on clock edge.
    logic [15:0] data_mem [4][256];
    logic [5:0]  tag_mem  [256];
    logic        dirty_mem[256];
    int          arr_wr_cnt = 0;

    initial begin
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 256; i++) data_mem[b][i] = 16'h0;
        for (int i = 0; i < 256; i++) begin
            tag_mem[i]   = 6'h0;
            dirty_mem[i] = 1'b0;
        end
    end

    assign bus.c_data_out  = bus.c_data_wr ? 16'h0 : data_mem[bus.c_offset][bus.c_index];
    assign bus.c_tag_out   = tag_mem[bus.c_index];
    assign bus.c_dirty_out = dirty_mem[bus.c_index];

    always @(posedge clk) begin
        if (bus.c_data_wr)  data_mem[bus.c_offset][bus.c_index] <= bus.c_data_in;
        if (bus.c_tag_wr)   tag_mem[bus.c_index] <= bus.c_tag_in;
        if (bus.c_dirty_wr) dirty_mem[bus.c_index] <= bus.c_dirty_in;
        if (bus.c_data_wr || bus.c_tag_wr || bus.c_dirty_wr) arr_wr_cnt <= arr_wr_cnt + 1;
    end

    // Backing memory: logs accepted requests, returns read data two cycles later.
    logic [15:0] mlog_addr[$];
    logic        mlog_wr[$];
    logic [15:0] mlog_data[$];
    logic [1:0]  rv_dly;
    logic [15:0] rd_addr;
    int          wb_acc = 0;
    int          stall_cnt = 0;

    // Stall the second write-back word for three cycles.
    assign bus.mem_stall  = bus.mem_req && bus.mem_wr && (wb_acc == 1) && (stall_cnt < 3);
    assign bus.mem_rvalid = (rv_dly == 2'd1);
    assign bus.mem_rdata  = bus.mem_rvalid ? (rd_addr ^ 16'hA5A5) : 16'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_dly  <= 2'd0;
            rd_addr <= 16'h0;
        end else begin
            if (rv_dly != 2'd0) rv_dly <= rv_dly - 2'd1;
            if (bus.mem_stall) stall_cnt <= stall_cnt + 1;
            if (bus.mem_req && !bus.mem_stall) begin
                mlog_addr.push_back(bus.mem_addr);
                mlog_wr.push_back(bus.mem_wr);
                mlog_data.push_back(bus.mem_wdata);
                if (bus.mem_wr) begin
                    wb_acc <= wb_acc + 1;
                end else begin
                    rv_dly  <= 2'd2;
                    rd_addr <= bus.mem_addr;
                end
            end
        end
    end

    // mem_addr/mem_wdata must hold while stalled.
    int          stall_obs = 0;
    logic [15:0] stall_addr;
    logic [15:0] stall_wdata;
    always @(negedge clk) begin
        if (bus.mem_stall) begin
            if (stall_obs == 0) begin
                stall_addr  <= bus.mem_addr;
                stall_wdata <= bus.mem_wdata;
            end else begin
                chk("stall_addr_hold", bus.mem_addr, stall_addr);
                chk("stall_wdata_hold", bus.mem_wdata, stall_wdata);
            end
            stall_obs <= stall_obs + 1;
        end
    end

    logic any_out;
    assign any_out = |{bus.busy, bus.done, bus.err, bus.rdata, bus.c_index, bus.c_offset,
                       bus.c_data_wr, bus.c_data_in, bus.c_tag_wr, bus.c_tag_in,
                       bus.c_dirty_wr, bus.c_dirty_in, bus.mem_req, bus.mem_wr,
                       bus.mem_addr, bus.mem_wdata};

    task automatic do_req(input string tag, input logic w, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output logic [15:0] rd);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        while (!bus.done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.rdata;
        chk({tag, "_done"}, bus.done, 1'b1);
        @(negedge clk);
    endtask

    int          lat;
    int          base;
    int          wr_base;
    logic [15:0] rd;
    logic [15:0] exp_d;

    initial begin
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 16'h0;
        bus.wdata = 16'h0;
        rst = 1'b1;
        #12;
        chk("rst_outs_zero", any_out, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Cold read miss on a clean, invalid line.
        base = mlog_addr.size();
        do_req("cold", 1'b0, 16'h0812, 16'h0, lat, rd);
        chk("cold_rdata", rd, 16'h0812 ^ 16'hA5A5);
        chk("cold_nreq", mlog_addr.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("cold_addr", mlog_addr[base+i], 16'h0810 + 16'(2 * i));
            chk("cold_is_rd", mlog_wr[base+i], 1'b0);
        end
        chk("cold_tag", tag_mem[2], 6'h21);
        chk("cold_dirty", dirty_mem[2], 1'b0);
        chk("cold_bank3", data_mem[3][2], 16'h0816 ^ 16'hA5A5);
        chk("cold_busy_after", bus.busy, 1'b0);

        // Write hit, then read-back hit.
        base = mlog_addr.size();
        do_req("wrhit", 1'b1, 16'h0814, 16'hBEEF, lat, rd);
        chk("wrhit_lat", lat, 1);
        chk("wrhit_no_mem", mlog_addr.size() - base, 0);
        chk("wrhit_dirty", dirty_mem[2], 1'b1);
        chk("wrhit_bank2", data_mem[2][2], 16'hBEEF);
        do_req("rdhit", 1'b0, 16'h0814, 16'h0, lat, rd);
        chk("rdhit_lat", lat, 1);
        chk("rdhit_rdata", rd, 16'hBEEF);

        // Dirty eviction, second write-back word stalled for three cycles.
        base = mlog_addr.size();
        do_req("evict", 1'b0, 16'h1014, 16'h0, lat, rd);
        chk("evict_rdata", rd, 16'h1014 ^ 16'hA5A5);
        chk("evict_nreq", mlog_addr.size() - base, 8);
        for (int i = 0; i < 4; i++) begin
            exp_d = (i == 2) ? 16'hBEEF : ((16'h0810 + 16'(2 * i)) ^ 16'hA5A5);
            chk("wb_addr", mlog_addr[base+i], 16'h0810 + 16'(2 * i));
            chk("wb_is_wr", mlog_wr[base+i], 1'b1);
            chk("wb_data", mlog_data[base+i], exp_d);
        end
        for (int i = 0; i < 4; i++) begin
            chk("refill_addr", mlog_addr[base+4+i], 16'h1010 + 16'(2 * i));
            chk("refill_is_rd", mlog_wr[base+4+i], 1'b0);
        end
        chk("stall_cycles", stall_obs, 3);
        chk("evict_tag", tag_mem[2], 6'h22);
        chk("evict_dirty", dirty_mem[2], 1'b0);

        // Unaligned request.
        base    = mlog_addr.size();
        wr_base = arr_wr_cnt;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = 16'h0003;
        @(negedge clk);
        bus.req = 1'b0;
        chk("unal_err", bus.err, 1'b1);
        chk("unal_done", bus.done, 1'b0);
        chk("unal_busy", bus.busy, 1'b0);
        @(negedge clk);
        chk("unal_err_pulse", bus.err, 1'b0);
        chk("unal_busy2", bus.busy, 1'b0);
        chk("unal_no_arr_wr", arr_wr_cnt - wr_base, 0);
        chk("unal_no_mem", mlog_addr.size() - base, 0);

        // Reset while waiting for refill data.
        base = mlog_addr.size();
        @(negedge clk);
        bus.req  = 1'b1;
        bus.addr = 16'h2018;
        @(negedge clk);
        bus.req = 1'b0;
        for (int i = 0; i < 50 && mlog_addr.size() == base; i++) @(negedge clk);
        chk("fw_reached", mlog_addr.size() > base, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_outs_zero", any_out, 1'b0);
        chk("midrst_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        do_req("post_rst", 1'b0, 16'h1016, 16'h0, lat, rd);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_rdata", rd, 16'h1016 ^ 16'hA5A5);
        chk("post_rst_tag3", tag_mem[3], 6'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back cache controller FSM. It sits directly upstream of the cache storage arrays: four data banks, one tag array and one dirty array, each 256 entries deep.
- Accepts 16-bit word read/write requests from the pipeline.
- On a hit, it accesses the arrays directly.
- On a miss, it writes back a dirty line word-by-word to the backing memory, refills the line, then replays the lookup.

Parameters:
- TAG_W, 5, tag width (address bits [15:11]).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  1  request valid, sampled only in IDLE
- wr  in  1  1=write, 0=read
- addr  in  16  byte address; [10:3]=index, [2:1]=word offset, [0] must be 0
- wdata  in  16  write data
- busy  out  1  controller not in IDLE
- done  out  1  one-cycle pulse, request complete
- rdata  out  16  read data, valid while done=1
- err  out  1  one-cycle pulse, unaligned address
- c_index  out  8  array address to all banks
- c_offset  out  2  bank select
- c_data_wr  out  1  write selected data bank
- c_data_in  out  16  data to selected bank
- c_data_out  in  16  selected bank read data (0 during a write cycle)
- c_tag_wr  out  1  write tag array
- c_tag_in  out  TAG_W+1  {valid,tag}
- c_tag_out  in  TAG_W+1  {valid,tag}
- c_dirty_wr  out  1  write dirty array
- c_dirty_in  out  1  dirty bit to write
- c_dirty_out  in  1  dirty bit read
- mem_req  out  1  backing-memory request
- mem_wr  out  1  1=write
- mem_addr  out  16  word-aligned byte address
- mem_wdata  out  16  write data
- mem_stall  in  1  request not accepted this cycle; hold all mem_* signals
- mem_rvalid  in  1  read data returned (at least 1 cycle after acceptance)
- mem_rdata  in  16  returned data

Behaviour:
- Reset (async): state=IDLE, word counter=0, latched addr/wdata/op=0. Every output is 0 while rst is high.
- Reset mid-operation aborts; mem_req drops in the same cycle. Array contents are the arrays' own concern.
- Array reads are combinational. Read data is never consumed in a cycle that writes the same array.
- States: IDLE, CMP, WB, FILL_REQ, FILL_WAIT, FILL_TAG.
- IDLE:
  - req=1 and addr[0]=1: err=1 next cycle, stay IDLE, no array or memory access.
  - req=1 and aligned: latch addr/wr/wdata, go to CMP.
  - req while busy is ignored.
- CMP: drive c_index=index, c_offset=offset. hit = valid & (tag match).
  - Read hit: done=1, rdata=c_data_out → IDLE. Hit latency: done in the cycle after req.
  - Write hit: c_data_wr=1, c_dirty_wr=1, c_dirty_in=1, done=1 → IDLE.
  - Miss with valid & dirty: counter=0 → WB.
  - Miss otherwise: counter=0 → FILL_REQ.
- WB: c_offset=counter. mem_req=1, mem_wr=1, mem_addr={old tag,index,counter,0}, mem_wdata=c_data_out.
  - Advance when mem_stall=0.
  - After word 3 is accepted → FILL_REQ with counter=0.
- FILL_REQ: mem_req=1, mem_wr=0, mem_addr={new tag,index,counter,0}. → FILL_WAIT when mem_stall=0.
- FILL_WAIT: on mem_rvalid, write c_data_in=mem_rdata at c_offset=counter with c_data_wr=1.
  - counter<3: counter+1 → FILL_REQ.
  - Otherwise → FILL_TAG.
- FILL_TAG: c_tag_wr=1, c_tag_in={1,new tag}, c_dirty_wr=1, c_dirty_in=0 → CMP (replay, guaranteed hit).
- Counter is 2 bits. Words are always transferred in order 0,1,2,3, regardless of the requested offset.
- mem_rvalid outside FILL_WAIT is ignored.
- Only one outstanding memory request at a time.
- busy=1 in every state except IDLE. done and err never assert together.

Test Plan:
- Cold read, addr=0x0812 after reset → one mem read each to 0x0810, 0x0812, 0x0814, 0x0816. Tag written {1,0x01}, dirty 0; done with rdata = word returned for 0x0812.
- Write hit: after the fill above, write 0x0814 with 0xBEEF → done in the cycle after req, no mem_req, dirty set. A following read of 0x0814 returns 0xBEEF, hit.
- Dirty eviction: read 0x1014 (same index, tag 0x02) → four mem writes to 0x0810–0x0816, with 0xBEEF at 0x0814. Then four reads from 0x1010–0x1016, tag {1,0x02}, dirty 0.
- Stall: hold mem_stall=1 for 3 cycles on the second WB word → mem_addr/mem_wdata stable throughout, no word skipped or duplicated.
- Unaligned: req with addr=0x0003 → err pulse next cycle, no done, no array writes, busy stays 0.
- Reset asserted in FILL_WAIT → all outputs 0 immediately. The next aligned request starts at CMP normally.
